block_emitter: RTL and testbench
================================

# block_emitter

Stream source for the keyword-block checker. It accepts open, close, separator and close-all commands over a valid/ready handshake. It serialises them one ASCII character per clock as space-terminated `begin` / `end` words with a per-command upper/lower-case mask, and tracks nesting depth so every bench stimulus carries its own expected balance result.

## Interface
- `DEPTH_W`, default 4: width of the nesting-depth counter; maximum depth is 2^DEPTH_W−1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block can accept a command this cycle.
- `cmd_op` in 2: 00 BEGIN, 01 END, 10 SPACE, 11 CLOSE_ALL.
- `cmd_case` in 5: uppercase mask; bit i=1 makes letter i of the word uppercase; bits above the word length are ignored.
- `out` out 8: ASCII character; 8'h20 when idle.
- `out_valid` out 1: `out` carries a command character this cycle.
- `depth` out DEPTH_W: current open-block count.
- `balanced` out 1: `depth`==0 and `err`==0.
- `err` out 1: sticky flag for underflow or overflow.

## Operation
- Handshake: a command transfers on a rising edge with `cmd_valid`&&`cmd_ready`. The op and case mask are latched; inputs are don't-care otherwise.
- FSM states: IDLE, EMIT_BEGIN, EMIT_END, EMIT_SP. A 3-bit character index counts within a word.
- BEGIN emits `b,e,g,i,n` then one space, 6 cycles. END emits `e,n,d` then one space, 4 cycles. SPACE emits a single 8'h20, 1 cycle.
- CLOSE_ALL loads a remaining counter with `depth` and emits `depth` END words, 4·depth cycles, all with the same case mask.
- CLOSE_ALL at depth 0 is accepted and emits nothing. `cmd_ready` stays high.
- Case rule: uppercase = lowercase − 8'h20, applied per latched mask bit.
- Depth updates on the edge that puts a word's trailing space on `out`:
  - BEGIN increments `depth`.
  - END decrements `depth`.
  - SPACE leaves `depth` unchanged.
- Underflow: an END at depth 0 is still emitted in full. `depth` stays 0 and `err` is set.
- Overflow: a BEGIN at maximum depth is still emitted. `depth` saturates and `err` is set.
- `err` clears only on reset.

## Timing
- Reset values:
  - `out`=8'h20
  - `out_valid`=0
  - `cmd_ready`=1
  - `depth`=0
  - `err`=0
  - `balanced`=1
  - FSM in IDLE
- Latency: the first character is on `out` in the cycle after acceptance. All outputs are registered.
- `cmd_ready` is high in IDLE. It is also high in the cycle the final trailing space of a command is on `out` (for CLOSE_ALL, the last space of the last END). A command accepted there has its first character in the next cycle, with no idle gap.
- `cmd_ready` is low in every other emitting cycle.
- `depth` and `balanced` reflect a word's effect in the same cycle its trailing space appears on `out`.
- When FSM returns to IDLE, `out_valid` drops and `out` returns to 8'h20 in the same cycle.
- Reset mid-word: asynchronous return to reset values. The partial word is truncated and no depth update occurs.

## Structure
- Package `block_pkg` holds:
  - op codes `OP_BEGIN`, `OP_END`, `OP_SPACE`, `OP_CLOSE_ALL`
  - ASCII constants for the lowercase keywords and `ASCII_SP`=8'h20
  - the FSM state enum
- Sub-module `keyword_rom`: combinational. Maps (word kind, index, case bit) to an ASCII byte. The top holds the FSM, counters and flags.

## Test plan
- Reset, then BEGIN with case 5'b00000 → `out` = "b","e","g","i","n"," " on cycles 1–6 after accept. `depth`=1 and `balanced`=0 on cycle 6.
- BEGIN with case 5'b10101 accepted back-to-back with END with case 5'b010 → "B","e","G","i","N"," ","e","N","d"," " with no gap. `cmd_ready` is high exactly on the cycle each space is output. Final `depth`=0, `balanced`=1.
- END at depth 0 → "end " emitted, `depth` stays 0, `err`=1, `balanced`=0. A subsequent BEGIN/END pair leaves `err`=1.
- Three BEGINs, then CLOSE_ALL with case 5'b111 → twelve cycles of "END " ×3. `depth` steps 2, 1, 0 on each space. `balanced`=1 at the end. `cmd_ready` is low throughout except on the final space.
- `DEPTH_W`=2: four BEGINs → `depth` saturates at 3 and `err`=1 on the fourth space.
- Drop `reset` after "b","e" have been output → `out`=8'h20, `out_valid`=0, `depth` unchanged at reset value 0. After release, the next BEGIN starts cleanly at "b".

Source files
------------

// File: rtl/block_pkg.sv
// Shared op codes, ASCII constants and FSM state encoding for the keyword-block stream source.
package block_pkg;

  localparam logic [1:0] OP_BEGIN     = 2'b00;
  localparam logic [1:0] OP_END       = 2'b01;
  localparam logic [1:0] OP_SPACE     = 2'b10;
  localparam logic [1:0] OP_CLOSE_ALL = 2'b11;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_B  = 8'h62;
  localparam logic [7:0] ASCII_E  = 8'h65;
  localparam logic [7:0] ASCII_G  = 8'h67;
  localparam logic [7:0] ASCII_I  = 8'h69;
  localparam logic [7:0] ASCII_N  = 8'h6e;
  localparam logic [7:0] ASCII_D  = 8'h64;

  // Lowercase minus this offset gives the uppercase letter.
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // Index of the trailing space within each word.
  localparam logic [2:0] BEGIN_LEN = 3'd5;
  localparam logic [2:0] END_LEN   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT_BEGIN,
    ST_EMIT_END,
    ST_EMIT_SP
  } state_e;

endpackage

// File: rtl/block_emitter_if.sv
// Command handshake into the emitter; a command transfers when valid and ready are both high.
interface block_emitter_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_case;

  modport master (output cmd_valid, output cmd_op, output cmd_case, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_case, output cmd_ready);
endinterface

// File: rtl/keyword_rom.sv
// Combinational character lookup: (word kind, index, case bit) -> ASCII byte, space when idle.
module keyword_rom
  import block_pkg::*;
(
  input  state_e     kind,
  input  logic [2:0] idx,
  input  logic       upper,
  output logic [7:0] ch
);

  logic [7:0] lower;
  logic       is_letter;

  always_comb begin
    lower     = ASCII_SP;
    is_letter = 1'b0;
    case (kind)
      ST_EMIT_BEGIN: begin
        is_letter = 1'b1;
        case (idx)
          3'd0:    lower = ASCII_B;
          3'd1:    lower = ASCII_E;
          3'd2:    lower = ASCII_G;
          3'd3:    lower = ASCII_I;
          3'd4:    lower = ASCII_N;
          default: is_letter = 1'b0;
        endcase
      end
      ST_EMIT_END: begin
        is_letter = 1'b1;
        case (idx)
          3'd0:    lower = ASCII_E;
          3'd1:    lower = ASCII_N;
          3'd2:    lower = ASCII_D;
          default: is_letter = 1'b0;
        endcase
      end
      default: ;
    endcase
    ch = (is_letter && upper) ? (lower - CASE_OFFSET) : lower;
  end

endmodule

// File: rtl/block_emitter.sv
// Serialises begin/end/space/close-all commands one char per clock, first char the cycle after accept.
// Ready only in idle or on a command's final space, so back-to-back commands stream without a gap.
module block_emitter
  import block_pkg::*;
#(
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  block_emitter_if.slave     cmd,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_e             state, state_n;
  logic [2:0]         idx, idx_n;
  logic [4:0]         mask, mask_n;
  logic               close_all, close_n;
  logic [DEPTH_W-1:0] rem, rem_n;
  logic               ready_q, ready_n;
  logic [DEPTH_W-1:0] depth_n;
  logic               err_n, balanced_n, out_valid_n;
  logic               accept, word_last, space_n;
  logic [7:0]         mask_ext;
  logic [7:0]         ch_n;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid && ready_q;

  // Current cycle shows the last character of a word.
  assign word_last = (state == ST_EMIT_BEGIN && idx == BEGIN_LEN) ||
                     (state == ST_EMIT_END   && idx == END_LEN)   ||
                     (state == ST_EMIT_SP);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    mask_n  = mask;
    close_n = close_all;
    rem_n   = rem;
    if (accept) begin
      mask_n  = cmd.cmd_case;
      idx_n   = 3'd0;
      close_n = 1'b0;
      case (cmd.cmd_op)
        OP_BEGIN: state_n = ST_EMIT_BEGIN;
        OP_END:   state_n = ST_EMIT_END;
        OP_SPACE: state_n = ST_EMIT_SP;
        default: begin
          close_n = 1'b1;
          rem_n   = depth;
          state_n = (depth == '0) ? ST_IDLE : ST_EMIT_END;
        end
      endcase
    end else if (state == ST_IDLE) begin
      state_n = ST_IDLE;
    end else if (word_last) begin
      idx_n   = 3'd0;
      state_n = (close_all && rem != '0) ? ST_EMIT_END : ST_IDLE;
    end else begin
      idx_n = idx + 3'd1;
      if (close_all && state == ST_EMIT_END && idx_n == END_LEN)
        rem_n = rem - 1'b1;
    end
  end

  // Depth and flags move on the edge that puts a word's trailing space on the output.
  always_comb begin
    space_n = (state_n == ST_EMIT_BEGIN && idx_n == BEGIN_LEN) ||
              (state_n == ST_EMIT_END   && idx_n == END_LEN)   ||
              (state_n == ST_EMIT_SP);
    depth_n = depth;
    err_n   = err;
    if (state_n == ST_EMIT_BEGIN && idx_n == BEGIN_LEN) begin
      if (depth == DEPTH_MAX) err_n = 1'b1;
      else                    depth_n = depth + 1'b1;
    end else if (state_n == ST_EMIT_END && idx_n == END_LEN) begin
      if (depth == '0) err_n = 1'b1;
      else             depth_n = depth - 1'b1;
    end
    balanced_n  = (depth_n == '0) && !err_n;
    ready_n     = (state_n == ST_IDLE) || (space_n && !(close_n && rem_n != '0));
    out_valid_n = (state_n != ST_IDLE);
    mask_ext    = {3'b000, mask_n};
  end

  keyword_rom u_rom (
    .kind  (state_n),
    .idx   (idx_n),
    .upper (mask_ext[idx_n]),
    .ch    (ch_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      mask      <= 5'd0;
      close_all <= 1'b0;
      rem       <= '0;
      ready_q   <= 1'b1;
      out       <= ASCII_SP;
      out_valid <= 1'b0;
      depth     <= '0;
      err       <= 1'b0;
      balanced  <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      mask      <= mask_n;
      close_all <= close_n;
      rem       <= rem_n;
      ready_q   <= ready_n;
      out       <= ch_n;
      out_valid <= out_valid_n;
      depth     <= depth_n;
      err       <= err_n;
      balanced  <= balanced_n;
    end
  end

endmodule

// File: tb/tb_block_emitter.sv
// Scoreboarded bench: each accepted command pushes its expected characters, ready, depth and flags.
module tb_block_emitter;
  import block_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] out, out2;
  logic       out_valid, out_valid2;
  logic [3:0] depth;
  logic [1:0] depth2;
  logic       balanced, balanced2, err, err2;

  block_emitter_if c ();
  block_emitter_if c2 ();

  block_emitter #(.DEPTH_W(4)) dut (
    .clk(clk), .reset(rst_n), .cmd(c.slave), .out(out), .out_valid(out_valid),
    .depth(depth), .balanced(balanced), .err(err)
  );

  block_emitter #(.DEPTH_W(2)) dut2 (
    .clk(clk), .reset(rst_n), .cmd(c2.slave), .out(out2), .out_valid(out_valid2),
    .depth(depth2), .balanced(balanced2), .err(err2)
  );

  typedef struct {
    logic [7:0] ch;
    logic       rdy;
    logic [3:0] dep;
    logic       bal;
    logic       er;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   model_depth = 0;
  logic model_err = 1'b0;

  function automatic exp_t mk(input logic [7:0] ch, input logic rdy);
    exp_t e;
    e.ch  = ch;
    e.rdy = rdy;
    e.dep = 4'(model_depth);
    e.bal = (model_depth == 0) && !model_err;
    e.er  = model_err;
    return e;
  endfunction

  function automatic void push_word(input string w, input logic [4:0] m, input int kind, input logic rdy_last);
    logic [7:0] ch;
    for (int i = 0; i < w.len(); i++) begin
      ch = w[i];
      if (m[i]) ch = ch - 8'h20;
      exp_q.push_back(mk(ch, 1'b0));
    end
    if (kind > 0) begin
      if (model_depth == 15) model_err = 1'b1;
      else model_depth++;
    end else if (kind < 0) begin
      if (model_depth == 0) model_err = 1'b1;
      else model_depth--;
    end
    exp_q.push_back(mk(8'h20, rdy_last));
  endfunction

  function automatic void push_cmd(input logic [1:0] op, input logic [4:0] m);
    int n;
    case (op)
      OP_BEGIN: push_word("begin", m, 1, 1'b1);
      OP_END:   push_word("end", m, -1, 1'b1);
      OP_SPACE: push_word("", m, 0, 1'b1);
      default: begin
        n = model_depth;
        for (int w = 0; w < n; w++) push_word("end", m, -1, w == n - 1);
      end
    endcase
  endfunction

  // Scoreboard monitor, sampling 2 time units after the active edge.
  always @(posedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra got ch=%h required no output", out);
      end else begin
        mon_e = exp_q.pop_front();
        if (out !== mon_e.ch || c.cmd_ready !== mon_e.rdy || depth !== mon_e.dep ||
            balanced !== mon_e.bal || err !== mon_e.er) begin
          errors++;
          $display("FAIL stream got ch=%h rdy=%b dep=%0d bal=%b err=%b required ch=%h rdy=%b dep=%0d bal=%b err=%b",
                   out, c.cmd_ready, depth, balanced, err, mon_e.ch, mon_e.rdy, mon_e.dep, mon_e.bal, mon_e.er);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [4:0] m);
    int n = 0;
    while (!c.cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!c.cmd_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout got ready=%b required 1", c.cmd_ready);
      return;
    end
    c.cmd_valid = 1'b1;
    c.cmd_op    = op;
    c.cmd_case  = m;
    push_cmd(op, m);
    @(negedge clk);
    c.cmd_valid = 1'b0;
    c.cmd_op    = 2'($urandom_range(0, 3));
    c.cmd_case  = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || out_valid) begin
      errors++; checks++;
      $display("FAIL drain_timeout got pending=%0d out_valid=%b required 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    c.cmd_valid = 1'b0; c.cmd_op = 2'b00; c.cmd_case = 5'd0;
    c2.cmd_valid = 1'b0; c2.cmd_op = 2'b00; c2.cmd_case = 5'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out !== 8'h20) begin errors++; $display("FAIL reset_out got=%h required=20", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    checks++; if (c.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", c.cmd_ready); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth got=%0d required=0", depth); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b required=0", err); end
    checks++; if (balanced !== 1'b1) begin errors++; $display("FAIL reset_balanced got=%b required=1", balanced); end
  endtask

  task automatic test_first_begin();
    send(OP_BEGIN, 5'b00000);
    checks++; if (out !== 8'h62 || out_valid !== 1'b1) begin errors++; $display("FAIL begin_latency got ch=%h vld=%b required ch=62 vld=1", out, out_valid); end
    drain();
    checks++; if (depth !== 4'd1 || balanced !== 1'b0) begin errors++; $display("FAIL begin_depth got dep=%0d bal=%b required dep=1 bal=0", depth, balanced); end
    send(OP_END, 5'b00000);
    drain();
  endtask

  task automatic test_back_to_back();
    send(OP_BEGIN, 5'b10101);
    send(OP_END, 5'b00010);
    checks++; if (out !== 8'h65 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got ch=%h vld=%b required ch=65 vld=1", out, out_valid); end
    drain();
    checks++; if (depth !== 4'd0 || balanced !== 1'b1) begin errors++; $display("FAIL b2b_final got dep=%0d bal=%b required dep=0 bal=1", depth, balanced); end
  endtask

  task automatic test_underflow();
    send(OP_END, 5'b00000);
    drain();
    checks++; if (depth !== 4'd0 || err !== 1'b1 || balanced !== 1'b0) begin errors++; $display("FAIL underflow got dep=%0d err=%b bal=%b required dep=0 err=1 bal=0", depth, err, balanced); end
    send(OP_BEGIN, 5'b00000);
    send(OP_END, 5'b00000);
    drain();
    checks++; if (err !== 1'b1 || depth !== 4'd0) begin errors++; $display("FAIL err_sticky got err=%b dep=%0d required err=1 dep=0", err, depth); end
  endtask

  task automatic test_reset_mid();
    send(OP_BEGIN, 5'b00000);
    @(negedge clk);
    checks++; if (out !== 8'h65) begin errors++; $display("FAIL mid_second_char got=%h required=65", out); end
    rst_n = 1'b0;
    #1;
    checks++; if (out !== 8'h20 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out got ch=%h vld=%b required ch=20 vld=0", out, out_valid); end
    checks++; if (depth !== 4'd0 || err !== 1'b0 || c.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state got dep=%0d err=%b rdy=%b required dep=0 err=0 rdy=1", depth, err, c.cmd_ready); end
    exp_q.delete();
    model_depth = 0;
    model_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(OP_BEGIN, 5'b00000);
    checks++; if (out !== 8'h62) begin errors++; $display("FAIL mid_restart got=%h required=62", out); end
    drain();
    send(OP_END, 5'b00000);
    drain();
  endtask

  task automatic test_close_all();
    for (int i = 0; i < 3; i++) send(OP_BEGIN, 5'b00000);
    send(OP_CLOSE_ALL, 5'b00111);
    checks++; if (out !== 8'h45 || c.cmd_ready !== 1'b0) begin errors++; $display("FAIL close_first got ch=%h rdy=%b required ch=45 rdy=0", out, c.cmd_ready); end
    drain();
    checks++; if (depth !== 4'd0 || balanced !== 1'b1) begin errors++; $display("FAIL close_final got dep=%0d bal=%b required dep=0 bal=1", depth, balanced); end
    send(OP_CLOSE_ALL, 5'b11111);
    checks++; if (out_valid !== 1'b0 || c.cmd_ready !== 1'b1 || out !== 8'h20) begin errors++; $display("FAIL close_empty got vld=%b rdy=%b ch=%h required vld=0 rdy=1 ch=20", out_valid, c.cmd_ready, out); end
  endtask

  task automatic test_space();
    send(OP_SPACE, 5'b11111);
    checks++; if (out !== 8'h20 || out_valid !== 1'b1) begin errors++; $display("FAIL space got ch=%h vld=%b required ch=20 vld=1", out, out_valid); end
    drain();
  endtask

  task automatic test_saturate();
    int spaces = 0;
    int n = 0;
    c2.cmd_op    = OP_BEGIN;
    c2.cmd_case  = 5'd0;
    c2.cmd_valid = 1'b1;
    while (spaces < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid2 && out2 == 8'h20) begin
        spaces++;
        if (spaces == 4) c2.cmd_valid = 1'b0;
        if (spaces == 1) begin
          checks++; if (depth2 !== 2'd1 || err2 !== 1'b0) begin errors++; $display("FAIL sat_first got dep=%0d err=%b required dep=1 err=0", depth2, err2); end
        end else if (spaces == 3) begin
          checks++; if (depth2 !== 2'd3 || err2 !== 1'b0) begin errors++; $display("FAIL sat_third got dep=%0d err=%b required dep=3 err=0", depth2, err2); end
        end else if (spaces == 4) begin
          checks++; if (depth2 !== 2'd3 || err2 !== 1'b1 || balanced2 !== 1'b0) begin errors++; $display("FAIL sat_fourth got dep=%0d err=%b bal=%b required dep=3 err=1 bal=0", depth2, err2, balanced2); end
        end
      end
    end
    c2.cmd_valid = 1'b0;
    if (spaces < 4) begin
      errors++; checks++;
      $display("FAIL sat_timeout got spaces=%0d required 4", spaces);
    end
    @(negedge clk);
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL sat_idle got vld=%b required 0", out_valid2); end
  endtask

  initial begin
    test_reset();
    test_first_begin();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_close_all();
    test_space();
    test_saturate();
    repeat (3) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover got=%0d required=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
